// File: rtl/pipe_load_wb_if.sv
// Load-pipe bus: load requests and memory writes in, completed loads out.
// The requester drives through master; pipe_load_wb sits on slave.
interface pipe_load_wb_if #(
  parameter int DW = 16,
  parameter int AW = 8,
  parameter int RW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] addr;
  logic [RW-1:0] rd;
  logic [2:0]    func;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] Zout;
  logic [RW-1:0] Zrd;
  logic [15:0]   load_count;

  modport master (
    output in_valid, addr, rd, func, wr_en, wr_addr, wr_data, out_ready,
    input  in_ready, out_valid, Zout, Zrd, load_count
  );

  modport slave (
    input  in_valid, addr, rd, func, wr_en, wr_addr, wr_data, out_ready,
    output in_ready, out_valid, Zout, Zrd, load_count
  );
endinterface

// File: rtl/pipe_load_wb.sv
// Three-stage load/writeback pipe: latch request, read data memory, post-process
// into Zout and the register bank. A stalled output freezes every stage.
module pipe_load_wb #(
  parameter int DW = 16,
  parameter int AW = 8,
  parameter int RW = 4
) (
  input logic           clk1,
  input logic           rst,
  pipe_load_wb_if.slave bus
);

  logic [DW-1:0] mem     [0:(2**AW)-1];
  logic [DW-1:0] regbank [0:(2**RW)-1];

  logic          stall;
  logic          v1_reg, v2_reg, v3_reg;
  logic [AW-1:0] s1_addr_reg;
  logic [RW-1:0] s1_rd_reg, s2_rd_reg, zrd_reg;
  logic [2:0]    s1_func_reg, s2_func_reg;
  logic [DW-1:0] mem_q_reg, fwd_data_reg, zout_reg;
  logic          fwd_hit_reg;
  logic [15:0]   count_reg;
  logic [DW-1:0] l23_data;
  logic [DW-1:0] post_next;

  assign stall          = v3_reg && !bus.out_ready;
  assign bus.in_ready   = !stall;
  assign bus.out_valid  = v3_reg;
  assign bus.Zout       = zout_reg;
  assign bus.Zrd        = zrd_reg;
  assign bus.load_count = count_reg;

  // Write port runs every edge regardless of stall; the S2 read is a registered
  // RAM read with a write-first bypass captured alongside it.
  always_ff @(posedge clk1) begin
    if (bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
    if (!stall) begin
      mem_q_reg    <= mem[s1_addr_reg];
      fwd_hit_reg  <= bus.wr_en && (bus.wr_addr == s1_addr_reg);
      fwd_data_reg <= bus.wr_data;
    end
  end

  assign l23_data = fwd_hit_reg ? fwd_data_reg : mem_q_reg;

  always_comb begin
    post_next = l23_data;
    case (s2_func_reg)
      3'd1:    post_next = '0 - l23_data;
      3'd2:    post_next = l23_data >> 1;
      3'd3:    post_next = l23_data << 1;
      3'd4:    post_next = {{(DW-8){1'b0}}, l23_data[7:0]};
      3'd5:    post_next = {{(DW-8){1'b0}}, l23_data[DW-1:DW-8]};
      default: post_next = l23_data;
    endcase
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      v1_reg      <= 1'b0;
      v2_reg      <= 1'b0;
      v3_reg      <= 1'b0;
      s1_addr_reg <= '0;
      s1_rd_reg   <= '0;
      s1_func_reg <= '0;
      s2_rd_reg   <= '0;
      s2_func_reg <= '0;
      zout_reg    <= '0;
      zrd_reg     <= '0;
      count_reg   <= '0;
    end else begin
      if (v3_reg && bus.out_ready) begin
        count_reg <= count_reg + 16'd1;
      end
      if (!stall) begin
        v1_reg <= bus.in_valid;
        if (bus.in_valid) begin
          s1_addr_reg <= bus.addr;
          s1_rd_reg   <= bus.rd;
          s1_func_reg <= bus.func;
        end
        v2_reg      <= v1_reg;
        s2_rd_reg   <= s1_rd_reg;
        s2_func_reg <= s1_func_reg;
        v3_reg      <= v2_reg;
        if (v2_reg) begin
          zout_reg <= post_next;
          zrd_reg  <= s2_rd_reg;
        end
      end
    end
  end

  // One bank write per load, on the edge it enters S3; reset suppresses it.
  always_ff @(posedge clk1) begin
    if (!rst && !stall && v2_reg) begin
      regbank[s2_rd_reg] <= post_next;
    end
  end

endmodule

// File: tb/tb_pipe_load_wb.sv
// Bench for pipe_load_wb: directed scenarios plus random traffic against a
// model that tracks loads by how many times the pipe has advanced.
module tb_pipe_load_wb;

  typedef struct {
    logic [7:0]  addr;
    logic [3:0]  rd;
    logic [2:0]  func;
    int          adv;
    logic [15:0] data;
  } ent_t;

  logic clk1;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  pipe_load_wb_if #(.DW(16), .AW(8), .RW(4)) bus ();

  pipe_load_wb #(.DW(16), .AW(8), .RW(4)) dut (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (bus)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic [15:0] mem_m [0:255];
  logic [15:0] reg_m [0:15];
  bit          reg_v [0:15];
  ent_t        q [$];
  int          adv_cnt = 0;
  logic [15:0] cnt_m = 16'd0;

  function automatic logic [15:0] post(input logic [15:0] x, input logic [2:0] f);
    int v;
    v = int'(x);
    case (f)
      3'd1:    v = (65536 - v) % 65536;
      3'd2:    v = v / 2;
      3'd3:    v = (v * 2) % 65536;
      3'd4:    v = v % 256;
      3'd5:    v = v / 256;
      default: v = v;
    endcase
    return 16'(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: drive inputs, compare outputs to the model, then
  // advance the model across the coming posedge.
  task automatic step(input logic iv, input logic [7:0] a, input logic [3:0] r,
                      input logic [2:0] f, input logic orr, input logic we,
                      input logic [7:0] wa, input logic [15:0] wd);
    bit          exp_ov;
    bit          stl;
    ent_t        e;
    logic [15:0] rv;
    bus.in_valid  = iv;
    bus.addr      = a;
    bus.rd        = r;
    bus.func      = f;
    bus.out_ready = orr;
    bus.wr_en     = we;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
    #1;
    exp_ov = (q.size() > 0) && (q[0].adv + 2 == adv_cnt);
    chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
    chk("in_ready", 32'(bus.in_ready), 32'(!(exp_ov && !orr)));
    chk("load_count", 32'(bus.load_count), 32'(cnt_m));
    if (exp_ov) begin
      chk("Zout", 32'(bus.Zout), 32'(q[0].data));
      chk("Zrd", 32'(bus.Zrd), 32'(q[0].rd));
      chk("regbank_at_S3", 32'(dut.regbank[q[0].rd]), 32'(q[0].data));
    end
    stl = exp_ov && !orr;
    if (!stl) begin
      // the youngest load, if it sits in S1, reads memory on this edge (write-first)
      if (q.size() > 0 && q[q.size()-1].adv == adv_cnt) begin
        e  = q[q.size()-1];
        rv = (we && wa == e.addr) ? wd : mem_m[e.addr];
        e.data = post(rv, e.func);
        q[q.size()-1] = e;
      end
      if (exp_ov) begin
        e = q.pop_front();
        cnt_m = cnt_m + 16'd1;
        reg_m[e.rd] = e.data;
        reg_v[e.rd] = 1'b1;
      end
      adv_cnt++;
      if (iv) q.push_back('{a, r, f, adv_cnt, 16'h0});
    end
    if (we) mem_m[wa] = wd;
    @(negedge clk1);
  endtask

  task automatic idle(input logic orr);
    step(1'b0, 8'h0, 4'h0, 3'h0, orr, 1'b0, 8'h0, 16'h0);
  endtask

  task automatic load(input logic [7:0] a, input logic [3:0] r, input logic [2:0] f);
    step(1'b1, a, r, f, 1'b1, 1'b0, 8'h0, 16'h0);
  endtask

  task automatic memwr(input logic [7:0] wa, input logic [15:0] wd);
    step(1'b0, 8'h0, 4'h0, 3'h0, 1'b1, 1'b1, wa, wd);
  endtask

  initial begin
    logic [15:0] d;
    rst = 1'b1;
    bus.in_valid = 0; bus.addr = 0; bus.rd = 0; bus.func = 0;
    bus.out_ready = 1; bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
    for (int i = 0; i < 16; i++) reg_v[i] = 1'b0;
    repeat (2) @(negedge clk1);
    #1;
    chk("reset_out_valid", 32'(bus.out_valid), 0);
    chk("reset_in_ready", 32'(bus.in_ready), 1);
    chk("reset_Zout", 32'(bus.Zout), 0);
    chk("reset_Zrd", 32'(bus.Zrd), 0);
    chk("reset_load_count", 32'(bus.load_count), 0);
    rst = 1'b0;
    @(negedge clk1);

    for (int i = 0; i < 256; i++) begin
      case (i)
        125: d = 16'd8;
        126: d = 16'd5;
        127: d = 16'h8001;
        128: d = 16'h4003;
        130: d = 16'h0000;
        140: d = 16'd7;
        141: d = 16'd9;
        default: d = 16'($urandom);
      endcase
      memwr(8'(i), d);
    end

    // single load, two-edge latency
    load(8'd125, 4'd10, 3'd0);
    idle(1'b1);
    chk("t1_not_yet_valid", 32'(bus.out_valid), 0);
    idle(1'b1);
    chk("t1_valid", 32'(bus.out_valid), 1);
    chk("t1_Zout", 32'(bus.Zout), 32'd8);
    chk("t1_Zrd", 32'(bus.Zrd), 32'd10);
    chk("t1_regbank10", 32'(dut.regbank[10]), 32'd8);
    idle(1'b1);
    chk("t1_load_count", 32'(bus.load_count), 32'd1);

    // back-to-back with negate / shift right / shift left
    load(8'd126, 4'd1, 3'd1);
    load(8'd127, 4'd2, 3'd2);
    load(8'd128, 4'd3, 3'd3);
    chk("t2_Zout0", 32'(bus.Zout), 32'hFFFB);
    idle(1'b1);
    chk("t2_Zout1", 32'(bus.Zout), 32'h4000);
    idle(1'b1);
    chk("t2_Zout2", 32'(bus.Zout), 32'h8006);
    idle(1'b1);
    chk("t2_load_count", 32'(bus.load_count), 32'd4);

    // stall with three loads in flight and a request waiting
    load(8'd126, 4'd1, 3'd0);
    load(8'd127, 4'd2, 3'd0);
    load(8'd128, 4'd3, 3'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'd203, 4'd4, 3'd0, 1'b0, 1'b0, 8'h0, 16'h0);
      chk("t3_hold_Zout", 32'(bus.Zout), 32'd5);
      chk("t3_hold_in_ready", 32'(bus.in_ready), 0);
      chk("t3_hold_count", 32'(bus.load_count), 32'd4);
      chk("t3_hold_reg2", 32'(dut.regbank[2]), 32'h4000);
      chk("t3_hold_reg3", 32'(dut.regbank[3]), 32'h8006);
    end
    repeat (4) idle(1'b1);
    chk("t3_reg1", 32'(dut.regbank[1]), 32'd5);
    chk("t3_reg2", 32'(dut.regbank[2]), 32'h8001);
    chk("t3_reg3", 32'(dut.regbank[3]), 32'h4003);
    chk("t3_load_count", 32'(bus.load_count), 32'd7);

    // write-first forward into the S2 read
    load(8'd130, 4'd5, 3'd0);
    memwr(8'd130, 16'h1234);
    idle(1'b1);
    chk("t4_fwd_Zout", 32'(bus.Zout), 32'h1234);
    idle(1'b1);
    memwr(8'd130, 16'h0000);
    load(8'd130, 4'd5, 3'd5);
    memwr(8'd130, 16'h1234);
    idle(1'b1);
    chk("t4_fwd_hi_Zout", 32'(bus.Zout), 32'h0012);
    idle(1'b1);

    // same destination twice: youngest wins
    load(8'd140, 4'd12, 3'd0);
    load(8'd141, 4'd12, 3'd0);
    repeat (3) idle(1'b1);
    chk("t5_reg12", 32'(dut.regbank[12]), 32'd9);
    chk("t5_load_count", 32'(bus.load_count), 32'd11);

    // reset with two loads in flight
    load(8'd150, 4'd1, 3'd0);
    load(8'd151, 4'd2, 3'd0);
    bus.in_valid = 1'b0;
    bus.wr_en    = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_out_valid", 32'(bus.out_valid), 0);
    chk("t6_Zout", 32'(bus.Zout), 0);
    chk("t6_load_count", 32'(bus.load_count), 0);
    q.delete();
    cnt_m = 16'd0;
    repeat (2) @(negedge clk1);
    rst = 1'b0;
    repeat (3) idle(1'b1);
    chk("t6_reg1_kept", 32'(dut.regbank[1]), 32'd5);
    chk("t6_reg2_kept", 32'(dut.regbank[2]), 32'h8001);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom), 3'($urandom),
           ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           8'($urandom), 16'($urandom));
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) idle(1'b1);
    chk("drain_empty", 32'(q.size()), 0);
    for (int i = 0; i < 16; i++) begin
      if (reg_v[i]) chk($sformatf("final_reg%0d", i), 32'(dut.regbank[i]), 32'(reg_m[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
